// File: rtl/pda_pkg.sv
// Shared types and defaults for the multi-term pushdown matcher.
package pda_pkg;

  localparam int PDA_NUM_TERMS = 3;
  localparam int PDA_CHAR_W    = 8;
  localparam int PDA_CNT_W     = 16;

  typedef enum logic [1:0] {
    PDA_ANY_EQ     = 2'd0,
    PDA_ALL_EQ     = 2'd1,
    PDA_FIRST_NEXT = 2'd2,
    PDA_FIRST_LAST = 2'd3
  } pda_mode_e;

  typedef enum logic {
    PDA_IDLE = 1'b0,
    PDA_RUN  = 1'b1
  } pda_state_e;

endpackage

// File: rtl/pda_sat_counter.sv
// Per-term saturating counter; load_one wins over clear, clear over inc.
// overflow pulses when an increment is attempted at full scale.
module pda_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             load_one,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_next,
  output logic             overflow
);

  // Next-count selection with saturation.
  always_comb begin
    count_next = count;
    overflow   = 1'b0;
    if (load_one) begin
      count_next = CNT_W'(1);
    end else if (clear) begin
      count_next = '0;
    end else if (inc) begin
      if (count == '1) overflow = 1'b1;
      else             count_next = count + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clock) begin
    if (reset) count <= '0;
    else       count <= count_next;
  end

endmodule

// File: rtl/pda_multi_term_matcher.sv
// Streaming recognizer for t0^n0 ... t(N-1)^n(N-1) with per-run count
// comparison under a latched equality mode.
module pda_multi_term_matcher
  import pda_pkg::*;
#(
  parameter int NUM_TERMS = PDA_NUM_TERMS,
  parameter int CHAR_W    = PDA_CHAR_W,
  parameter int CNT_W     = PDA_CNT_W
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic [CHAR_W-1:0]           in_char,
  input  logic                        in_last,
  input  logic [NUM_TERMS*CHAR_W-1:0] terms,
  input  logic [1:0]                  mode,
  output logic                        match_valid,
  output logic                        matched,
  output logic [CNT_W-1:0]            first_count
);

  localparam int PW = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;
  localparam logic [PW-1:0] LAST_PH = PW'(NUM_TERMS - 1);

  pda_state_e       state_q, state_d;
  logic [PW-1:0]    phase_q, phase_d;
  pda_mode_e        mode_q, mode_d;
  logic             ovf_q, ovf_d;

  logic [CHAR_W-1:0] term_a [NUM_TERMS];
  logic [CNT_W-1:0]  cnt_q  [NUM_TERMS];
  logic [CNT_W-1:0]  cnt_d  [NUM_TERMS];
  logic [CNT_W-1:0]  fin    [NUM_TERMS];
  logic [NUM_TERMS-1:0] clr, ld, inc, ovf_pulse;

  logic hit_first, hit_cur, hit_nxt;
  logic start, eval_term, eval_upd, eval;
  logic fin_ovf, any_eq, all_eq, pred;

  genvar g;
  generate
    for (g = 0; g < NUM_TERMS; g++) begin : g_term
      assign term_a[g] = terms[g*CHAR_W +: CHAR_W];
      pda_sat_counter #(.CNT_W(CNT_W)) u_cnt (
        .clock      (clock),
        .reset      (reset),
        .clear      (clr[g]),
        .load_one   (ld[g]),
        .inc        (inc[g]),
        .count      (cnt_q[g]),
        .count_next (cnt_d[g]),
        .overflow   (ovf_pulse[g])
      );
    end
  endgenerate

  // Character classification against the current, next and first terms.
  always_comb begin
    hit_first = (in_char == term_a[0]);
    hit_cur   = 1'b0;
    hit_nxt   = 1'b0;
    for (int unsigned i = 0; i < NUM_TERMS; i++) begin
      if (PW'(i) == phase_q && in_char == term_a[i]) hit_cur = 1'b1;
      if (i > 0 && PW'(i - 1) == phase_q && in_char == term_a[i]) hit_nxt = 1'b1;
    end
  end

  // Next-state, counter controls and evaluation triggers.
  // A terminating char is re-examined as if in IDLE so t0 restarts in place;
  // in_last then evaluates using the post-update counts (eval_upd).
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    mode_d    = mode_q;
    ovf_d     = ovf_q | (|ovf_pulse);
    clr       = '0;
    ld        = '0;
    inc       = '0;
    start     = 1'b0;
    eval_term = 1'b0;
    eval_upd  = 1'b0;
    if (in_valid) begin
      case (state_q)
        PDA_IDLE: start = hit_first;
        PDA_RUN: begin
          if (hit_cur) begin
            for (int unsigned i = 0; i < NUM_TERMS; i++)
              if (PW'(i) == phase_q) inc[i] = 1'b1;
          end else if (hit_nxt) begin
            phase_d = phase_q + 1'b1;
            for (int unsigned i = 0; i < NUM_TERMS; i++)
              if (PW'(i) == phase_d) ld[i] = 1'b1;
          end else begin
            eval_term = (phase_q == LAST_PH);
            start     = hit_first;
            state_d   = PDA_IDLE;
          end
        end
        default: state_d = PDA_IDLE;
      endcase
      if (start) begin
        state_d = PDA_RUN;
        phase_d = '0;
        mode_d  = pda_mode_e'(mode);
        ovf_d   = 1'b0;
        clr     = '1;
        ld[0]   = 1'b1;
      end
      if (in_last) begin
        eval_upd = (state_d == PDA_RUN) && (phase_d == LAST_PH);
        state_d  = PDA_IDLE;
      end
    end
  end

  assign eval = eval_term | eval_upd;

  // Mode predicate over the final counts of the run being evaluated.
  always_comb begin
    fin_ovf = eval_upd ? (ovf_q | (|ovf_pulse)) : ovf_q;
    for (int unsigned i = 0; i < NUM_TERMS; i++)
      fin[i] = eval_upd ? cnt_d[i] : cnt_q[i];
    any_eq = 1'b0;
    all_eq = 1'b1;
    for (int unsigned i = 1; i < NUM_TERMS; i++) begin
      if (fin[i] == fin[0]) any_eq = 1'b1;
      else                  all_eq = 1'b0;
    end
    case (mode_q)
      PDA_ANY_EQ:     pred = any_eq;
      PDA_ALL_EQ:     pred = all_eq;
      PDA_FIRST_NEXT: pred = (fin[1] == fin[0]);
      PDA_FIRST_LAST: pred = (fin[NUM_TERMS-1] == fin[0]);
      default:        pred = 1'b0;
    endcase
  end

  // Control state and registered result.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= PDA_IDLE;
      phase_q     <= '0;
      mode_q      <= PDA_ANY_EQ;
      ovf_q       <= 1'b0;
      match_valid <= 1'b0;
      matched     <= 1'b0;
      first_count <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      mode_q      <= mode_d;
      ovf_q       <= ovf_d;
      match_valid <= eval;
      matched     <= eval & ~fin_ovf & pred;
      if (eval) first_count <= fin[0];
    end
  end

endmodule
